// File: rtl/shift_rx_ctrl_if.sv
// Handshake/data bundle between a serial-to-parallel receiver and its producer/consumer.
interface shift_rx_ctrl_if #(parameter int M = 5);
  logic         start;
  logic         bit_in;
  logic         ready;
  logic [M-1:0] byte_out;
  logic         valid;
  logic         busy;
  logic         shift_tick;
  logic         overrun;

  modport master (
    output start, bit_in, ready,
    input  byte_out, valid, busy, shift_tick, overrun
  );

  modport slave (
    input  start, bit_in, ready,
    output byte_out, valid, busy, shift_tick, overrun
  );
endinterface

// File: rtl/shift_rx_ctrl.sv
// Serial-to-parallel receiver: captures M bits LSB-first, one bit every DIV clocks,
// then holds the word until the consumer takes it with valid && ready.
module shift_rx_ctrl #(
  parameter int M   = 5,
  parameter int DIV = 4
) (
  input  logic            clk,
  input  logic            reset,
  shift_rx_ctrl_if.slave  bus
);
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BCW = $clog2(M + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t         state;
  logic [DCW-1:0] div_cnt;
  logic [BCW-1:0] bit_cnt;
  logic [M-1:0]   word_q;
  logic           overrun_q;
  logic           tick;

  // With DIV=1 the divider is stuck at 0, so tick is held for the whole SHIFT state.
  assign tick           = (state == SHIFT) && (div_cnt == DCW'(DIV - 1));

  assign bus.byte_out   = word_q;
  assign bus.valid      = (state == HOLD);
  assign bus.busy       = (state == SHIFT);
  assign bus.shift_tick = tick;
  assign bus.overrun    = overrun_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      word_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= SHIFT;
            div_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (bus.start) overrun_q <= 1'b1;
          if (tick) begin
            div_cnt <= '0;
            word_q  <= {bus.bit_in, word_q[M-1:1]};
            // bit_cnt returns to 0 on the last bit so it never reads M inside SHIFT
            if (bit_cnt == BCW'(M - 1)) begin
              bit_cnt <= '0;
              state   <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (bus.ready) begin
            if (bus.start) begin
              state   <= SHIFT;
              div_cnt <= '0;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (bus.start) begin
            overrun_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_rx_ctrl.sv
// Directed bench: one M=5/DIV=4 receiver and one M=5/DIV=1 receiver on a shared clock and reset.
module tb_shift_rx_ctrl;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  shift_rx_ctrl_if #(.M(5)) bus0 ();
  shift_rx_ctrl_if #(.M(5)) bus1 ();

  shift_rx_ctrl #(.M(5), .DIV(4)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  shift_rx_ctrl #(.M(5), .DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_byte0"},  {27'd0, bus0.byte_out}, 32'd0);
    chk({tag, "_valid0"}, {31'd0, bus0.valid},    32'd0);
    chk({tag, "_busy0"},  {31'd0, bus0.busy},     32'd0);
    chk({tag, "_tick0"},  {31'd0, bus0.shift_tick}, 32'd0);
    chk({tag, "_ovr0"},   {31'd0, bus0.overrun},  32'd0);
    chk({tag, "_byte1"},  {27'd0, bus1.byte_out}, 32'd0);
    chk({tag, "_valid1"}, {31'd0, bus1.valid},    32'd0);
    chk({tag, "_tick1"},  {31'd0, bus1.shift_tick}, 32'd0);
  endtask

  // Called one step after E0; runs the 20 cycles of a DIV=4 word, driving the
  // wanted bit only in tick cycles and its complement otherwise.
  task automatic run_word(input logic [4:0] bits, input int pulse_cyc, input logic rdy);
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 4; c++) begin
        bus0.start = ((k * 4 + c) == pulse_cyc);
        bus0.ready = rdy;
        chk("w_busy",  {31'd0, bus0.busy},       32'd1);
        chk("w_valid", {31'd0, bus0.valid},      32'd0);
        chk("w_tick",  {31'd0, bus0.shift_tick}, (c == 3) ? 32'd1 : 32'd0);
        bus0.bit_in = (c == 3) ? bits[k] : ~bits[k];
        tick();
      end
    end
    bus0.start = 1'b0;
    chk("w_done_valid", {31'd0, bus0.valid},    32'd1);
    chk("w_done_busy",  {31'd0, bus0.busy},     32'd0);
    chk("w_done_byte",  {27'd0, bus0.byte_out}, {27'd0, bits});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    bus0.start = 1'b0; bus0.bit_in = 1'b0; bus0.ready = 1'b0;
    bus1.start = 1'b0; bus1.bit_in = 1'b0; bus1.ready = 1'b0;
    reset = 1'b1;
    #2;
    chk_all_zero("rst");
    tick();
    tick();
    reset = 1'b0;

    // Word 1: bits 1,0,1,1,0 first-to-last -> 5'b01101
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    run_word(5'b01101, -1, 1'b0);
    chk("w1_ovr", {31'd0, bus0.overrun}, 32'd0);

    // Stall in HOLD with bit_in toggling
    for (int i = 0; i < 10; i++) begin
      bus0.ready  = 1'b0;
      bus0.bit_in = i[0];
      tick();
      chk("hold_byte",  {27'd0, bus0.byte_out}, 32'h0D);
      chk("hold_valid", {31'd0, bus0.valid},    32'd1);
      chk("hold_ovr",   {31'd0, bus0.overrun},  32'd0);
    end

    // Handshake with start: back-to-back word, start pulsed mid-capture
    bus0.ready = 1'b1;
    bus0.start = 1'b1;
    tick();
    bus0.ready = 1'b0;
    bus0.start = 1'b0;
    chk("b2b_busy", {31'd0, bus0.busy},    32'd1);
    chk("b2b_ovr",  {31'd0, bus0.overrun}, 32'd0);
    run_word(5'b10010, 6, 1'b0);
    chk("w2_ovr", {31'd0, bus0.overrun}, 32'd1);

    // Handshake without start -> IDLE, word and overrun retained
    bus0.ready = 1'b1;
    tick();
    bus0.ready = 1'b0;
    chk("idle_valid", {31'd0, bus0.valid},    32'd0);
    chk("idle_busy",  {31'd0, bus0.busy},     32'd0);
    chk("idle_byte",  {27'd0, bus0.byte_out}, 32'h12);
    chk("idle_ovr",   {31'd0, bus0.overrun},  32'd1);

    // Word 3 aborted by async reset after three shifts of 1
    bus0.start = 1'b1;
    tick();
    bus0.start  = 1'b0;
    bus0.bit_in = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("pre_rst_byte", {27'd0, bus0.byte_out}, 32'h1E);
    chk("pre_rst_busy", {31'd0, bus0.busy},     32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("arst");
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("post_rst_valid", {31'd0, bus0.valid}, 32'd0);
      chk("post_rst_busy",  {31'd0, bus0.busy},  32'd0);
    end

    // Fresh word right after reset recovery, ready held high throughout SHIFT
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    chk("w4_busy", {31'd0, bus0.busy}, 32'd1);
    run_word(5'b10110, -1, 1'b1);
    chk("w4_ovr", {31'd0, bus0.overrun}, 32'd0);
    tick();
    bus0.ready = 1'b0;
    chk("w4_drain_valid", {31'd0, bus0.valid}, 32'd0);

    // DIV=1 receiver: five ones back-to-back
    bus1.start = 1'b1;
    tick();
    bus1.start  = 1'b0;
    bus1.bit_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("d1_tick",  {31'd0, bus1.shift_tick}, 32'd1);
      chk("d1_valid", {31'd0, bus1.valid},      32'd0);
      tick();
    end
    chk("d1_done_valid", {31'd0, bus1.valid},    32'd1);
    chk("d1_done_tick",  {31'd0, bus1.shift_tick}, 32'd0);
    chk("d1_done_byte",  {27'd0, bus1.byte_out}, 32'h1F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shift_rx_ctrl.md
SHIFT_RX_CTRL -- requirements
Module: shift_rx_ctrl

Interface
REQ-001 The block SHALL have parameter M, default 5, giving the parallel word width in bits (M >= 2).
REQ-002 The block SHALL have parameter DIV, default 4, giving the clock cycles per serial bit (DIV >= 1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to capture one M-bit word.
REQ-006 The block SHALL have port bit_in, input, 1 bit: serial data, sampled only on shift edges.
REQ-007 The block SHALL have port ready, input, 1 bit: consumer accepts byte_out when valid=1.
REQ-008 The block SHALL have port byte_out, output reg, M bits: assembled parallel word.
REQ-009 The block SHALL have port valid, output, 1 bit: byte_out holds a complete word.
REQ-010 The block SHALL have port busy, output, 1 bit: high in the SHIFT state.
REQ-011 The block SHALL have port shift_tick, output, 1 bit: high during the cycle whose closing edge performs a shift.
REQ-012 The block SHALL have port overrun, output, 1 bit: sticky flag set when start is dropped.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and HOLD. valid SHALL be 1 only in HOLD; busy SHALL be 1 only in SHIFT.
REQ-014 In IDLE, start=1 SHALL move the FSM to SHIFT on that edge (E0) and clear div_cnt and bit_cnt to 0; byte_out SHALL be unchanged.
REQ-015 In SHIFT, div_cnt SHALL count 0..DIV-1 and wrap; shift_tick SHALL equal (state==SHIFT && div_cnt==DIV-1), decoded combinationally.
REQ-016 On each edge with shift_tick=1, the block SHALL set byte_out <= {bit_in, byte_out[M-1:1]} and increment bit_cnt.
  - The first received bit SHALL end up in byte_out[0] and the last in byte_out[M-1].
REQ-017 Shifts SHALL occur at edges E0+k*DIV for k = 1..M; the edge at E0+M*DIV SHALL also move the FSM to HOLD. valid SHALL be first high in the cycle after that edge.
REQ-018 With DIV=1, the block SHALL shift on every cycle in SHIFT, with shift_tick constantly high there.
REQ-019 bit_cnt SHALL be ceil(log2(M+1)) bits wide and SHALL never exceed M-1 when sampled in SHIFT.
REQ-020 In HOLD, byte_out SHALL stay stable until the handshake (valid && ready) at an edge.
REQ-021 On the handshake edge, the FSM SHALL go to SHIFT if start=1 in that same cycle (counters cleared); otherwise it SHALL go to IDLE.
REQ-022 start=1 in SHIFT, or in HOLD without ready=1, SHALL be ignored and SHALL set overrun=1 on that edge.
REQ-023 overrun SHALL be cleared only by reset.
REQ-024 ready in IDLE or SHIFT SHALL have no effect; bit_in outside shift edges SHALL have no effect.

Reset
REQ-025 reset=1 SHALL immediately, independent of clk, force: state IDLE, div_cnt=0, bit_cnt=0, byte_out=0, valid=0, busy=0, shift_tick=0, overrun=0.
REQ-026 Reset asserted mid-SHIFT or in HOLD SHALL abort the word; no valid SHALL follow reset release without a new start.
REQ-027 The first rising clk edge with reset=0 SHALL be a normal operating edge.

Verification
REQ-028 M=5, DIV=4: start pulse, bits 1,0,1,1,0 presented at shift edges -> shift_tick 5 times, 4 cycles apart; valid high after edge E0+20; byte_out=5'b01101.
REQ-029 Hold valid with ready=0 for 10 cycles while toggling bit_in -> byte_out stays 5'b01101; valid stays 1; overrun stays 0.
REQ-030 ready=1 and start=1 in the same HOLD cycle -> the next word begins on that edge with no IDLE cycle; busy=1 the following cycle.
REQ-031 start pulsed during SHIFT -> the capture is unaffected and overrun=1 until reset.
REQ-032 reset asserted asynchronously after 3 shifts -> all outputs 0 at once; after release with no start, valid stays 0 for 30 cycles.
REQ-033 DIV=1, M=5: start, then bits 1,1,1,1,1 -> valid high after edge E0+5; byte_out=5'b11111.
